// File: rtl/ram_lsu_bridge.sv
// Byte/half/word load-store master for a dual-port word RAM without byte enables.
// Optional `LSU_MISALIGN_ERR_EN: misaligned or reserved-size requests complete at once with rsp_err.
module ram_lsu_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_CAPT, RMW_WRITE} state_t;

  state_t                state;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  uns_q;
  logic [15:0]           wdata_q;
  logic                  accept;
  logic                  misalign;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_ERR_EN
  assign misalign = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Half accesses use only lane[1]; word (and size 11) ignore the lane entirely.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    h  = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_ext = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] nd,
                                        input logic [1:0] lane, input logic size0);
    logic [31:0] mask;
    mask = 32'h0000_00ff << {lane, 3'b000};
    if (size0)
      merge = lane[1] ? {nd, w[15:0]} : {w[31:16], nd};
    else
      merge = (w & ~mask) | ({24'h0, nd[7:0]} << {lane, 3'b000});
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      ram_w_en   <= 1'b0;
      ram_w_addr <= '0;
      ram_w_data <= '0;
      ram_r_en   <= 1'b0;
      ram_r_addr <= '0;
    end else begin
      rsp_valid <= 1'b0;
      ram_w_en  <= 1'b0;
      ram_r_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
            if (misalign) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && req_size[1]) begin
              state      <= WR_ISSUE;
              ram_w_en   <= 1'b1;
              ram_w_addr <= req_addr[ADDR_WIDTH+1:2];
              ram_w_data <= req_wdata;
            end else begin
              state      <= RD_ISSUE;
              ram_r_en   <= 1'b1;
              ram_r_addr <= req_addr[ADDR_WIDTH+1:2];
            end
          end
        end
        WR_ISSUE, RMW_WRITE: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RD_ISSUE: state <= RD_CAPT;
        RD_CAPT: begin
          if (we_q) begin
            state      <= RMW_WRITE;
            ram_w_en   <= 1'b1;
            ram_w_addr <= addr_q[ADDR_WIDTH+1:2];
            ram_w_data <= merge(ram_r_data, wdata_q, addr_q[1:0], size_q[0]);
          end else begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_ext(ram_r_data, addr_q[1:0], size_q, uns_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu_bridge.sv
// Directed bench for ram_lsu_bridge with a behavioural word RAM (1-cycle read latency).
module tb_ram_lsu_bridge;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          ram_w_en;
  logic [AW-1:0] ram_w_addr;
  logic [31:0]   ram_w_data;
  logic          ram_r_en;
  logic [AW-1:0] ram_r_addr;
  logic [31:0]   ram_r_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int overlap = 0;
  int wen_cnt = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_lsu_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr),
    .ram_r_data(ram_r_data)
  );

  always @(posedge clk) begin
    ram_r_data <= ram_r_en ? mem[ram_r_addr] : 32'h0;
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
  end

  always @(negedge clk) begin
    if (ram_w_en && ram_r_en) overlap++;
    if (ram_w_en) wen_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for ready, returns in cycle 1 after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW+1:0] a, input logic [31:0] wd);
    int n;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_issue", {31'h0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [AW+1:0] a, input logic [31:0] exp);
    issue(1'b0, size, uns, a, 32'h0);
    check({tag, "_r_en"}, {31'h0, ram_r_en}, 32'h1);
    check({tag, "_r_addr"}, {20'h0, ram_r_addr}, {20'h0, a[AW+1:2]});
    tick();
    check({tag, "_c2_valid"}, {31'h0, rsp_valid}, 32'h0);
    tick();
    check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_rdata"}, rsp_rdata, exp);
  endtask

  task automatic do_store_sub(input string tag, input logic [1:0] size, input logic [AW+1:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_w);
    issue(1'b1, size, 1'b0, a, wd);
    check({tag, "_r_en"}, {31'h0, ram_r_en}, 32'h1);
    tick();
    check({tag, "_c2_w_en"}, {31'h0, ram_w_en}, 32'h0);
    tick();
    check({tag, "_w_en"}, {31'h0, ram_w_en}, 32'h1);
    check({tag, "_w_addr"}, {20'h0, ram_w_addr}, {20'h0, a[AW+1:2]});
    check({tag, "_w_data"}, ram_w_data, exp_w);
    tick();
    check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h0);
    check({tag, "_w_en"}, {31'h0, ram_w_en}, 32'h0);
    check({tag, "_r_en"}, {31'h0, ram_r_en}, 32'h0);
    check({tag, "_w_addr"}, {20'h0, ram_w_addr}, 32'h0);
    check({tag, "_w_data"}, ram_w_data, 32'h0);
    check({tag, "_r_addr"}, {20'h0, ram_r_addr}, 32'h0);
    check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
  endtask

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("ready_idle", {31'h0, req_ready}, 32'h1);

    // Word store
    issue(1'b1, 2'b10, 1'b0, 14'h020, 32'hDEADBEEF);
    check("wst_w_en", {31'h0, ram_w_en}, 32'h1);
    check("wst_w_addr", {20'h0, ram_w_addr}, 32'h008);
    check("wst_w_data", ram_w_data, 32'hDEADBEEF);
    check("wst_r_en", {31'h0, ram_r_en}, 32'h0);
    check("wst_c1_valid", {31'h0, rsp_valid}, 32'h0);
    tick();
    check("wst_valid", {31'h0, rsp_valid}, 32'h1);
    check("wst_rdata", rsp_rdata, 32'h0);
    check("wst_err", {31'h0, rsp_err}, 32'h0);
    check("wst_c2_w_en", {31'h0, ram_w_en}, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 14'h010, 32'h8899AABB);
    tick();
    check("pre_valid", {31'h0, rsp_valid}, 32'h1);

    do_load("lb_s", 2'b00, 1'b0, 14'h013, 32'hFFFFFF88);
    do_load("lb_u", 2'b00, 1'b1, 14'h013, 32'h00000088);
    do_load("lh_s", 2'b01, 1'b0, 14'h010, 32'hFFFFAABB);
    tick();
    check("hold_valid", {31'h0, rsp_valid}, 32'h0);
    check("hold_rdata", rsp_rdata, 32'hFFFFAABB);

    do_store_sub("sh", 2'b01, 14'h012, 32'h00001234, 32'h1234AABB);
    do_store_sub("sb", 2'b00, 14'h011, 32'h0000005A, 32'h12345ABB);
    do_load("lw", 2'b10, 1'b0, 14'h010, 32'h12345ABB);

    // Back-to-back loads with req_valid held; inputs change after acceptance
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 14'h010;
    req_valid = 1'b1;
    tick();
    req_size = 2'b00; req_unsigned = 1'b1; req_addr = 14'h011;
    check("b2b_c1_ready", {31'h0, req_ready}, 32'h0);
    tick();
    check("b2b_c2_ready", {31'h0, req_ready}, 32'h0);
    tick();
    check("b2b_c3_valid", {31'h0, rsp_valid}, 32'h1);
    check("b2b_c3_rdata", rsp_rdata, 32'h12345ABB);
    check("b2b_c3_ready", {31'h0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
    check("b2b_c4_r_en", {31'h0, ram_r_en}, 32'h1);
    check("b2b_c4_valid", {31'h0, rsp_valid}, 32'h0);
    tick();
    check("b2b_c5_valid", {31'h0, rsp_valid}, 32'h0);
    tick();
    check("b2b_c6_valid", {31'h0, rsp_valid}, 32'h1);
    check("b2b_c6_rdata", rsp_rdata, 32'h0000005A);

    // Reset during RD_CAPT of a byte store
    issue(1'b1, 2'b00, 1'b0, 14'h010, 32'h000000EE);
    tick();
    w0 = wen_cnt;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_no_wen", wen_cnt, w0);
    check("midrst_no_valid", {31'h0, rsp_valid}, 32'h0);
    do_load("midrst_lw", 2'b10, 1'b0, 14'h010, 32'h12345ABB);

    // Misaligned half load
    issue(1'b0, 2'b01, 1'b0, 14'h011, 32'h0);
`ifdef LSU_MISALIGN_ERR_EN
    check("mis_valid", {31'h0, rsp_valid}, 32'h1);
    check("mis_err", {31'h0, rsp_err}, 32'h1);
    check("mis_rdata", rsp_rdata, 32'h0);
    check("mis_r_en", {31'h0, ram_r_en}, 32'h0);
    check("mis_ready", {31'h0, req_ready}, 32'h1);
    tick();
    check("mis_c2_valid", {31'h0, rsp_valid}, 32'h0);
    check("mis_c2_r_en", {31'h0, ram_r_en}, 32'h0);
`else
    check("mis_r_en", {31'h0, ram_r_en}, 32'h1);
    check("mis_r_addr", {20'h0, ram_r_addr}, 32'h004);
    tick();
    tick();
    check("mis_valid", {31'h0, rsp_valid}, 32'h1);
    check("mis_rdata", rsp_rdata, 32'h00005ABB);
    check("mis_err", {31'h0, rsp_err}, 32'h0);
`endif

    tick();
    check("rw_exclusive", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
